imem_load_ctrl: RTL and testbench

//  Owns the single address/write port of the 64x32 instruction memory and shares it

---
 rtl/imem_load_ctrl_pkg.sv | 24 ++
 rtl/imem_load_ctrl_if.sv | 30 +++
 rtl/imem_csum_acc.sv | 45 ++++
 rtl/imem_load_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Contents:
//   IMEM_DEPTH       default instruction memory depth in 32-bit words
//   IMEM_DATA_W      memory word width
//   imem_ld_state_t  controller FSM states
//   byte_addr()      turns a word index into a word-aligned byte address
package imem_ctrl_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } imem_ld_state_t;

  // Word index to byte address; the two low byte bits are always zero.
  function automatic logic [31:0] byte_addr(input logic [29:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader stream plus instruction-memory port bundle.
// Signals:
//   ld_valid / ld_data / ld_ready   loader word handshake (loader -> controller)
//   mem_addr / mem_wdata / mem_we   memory address and write port (controller -> memory)
//   mem_rdata                       asynchronous read data (memory -> controller)
// Modports:
//   master  environment side: loader source and memory model
//   slave   controller side
interface imem_load_ctrl_if;
  import imem_ctrl_pkg::*;

  logic                   ld_valid;
  logic [IMEM_DATA_W-1:0] ld_data;
  logic                   ld_ready;
  logic [31:0]            mem_addr;
  logic [IMEM_DATA_W-1:0] mem_wdata;
  logic                   mem_we;
  logic [IMEM_DATA_W-1:0] mem_rdata;

  modport master (
    output ld_valid, ld_data, mem_rdata,
    input  ld_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  ld_valid, ld_data, mem_rdata,
    output ld_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/imem_csum_acc.sv
// 32-bit XOR accumulator with synchronous clear and enable.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears the sum)
//   clr_i       clear the sum to zero (takes priority over en_i)
//   en_i        fold data_i into the sum
//   data_i      word to accumulate
//   acc_o       current registered sum
module imem_csum_acc
  import imem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [IMEM_DATA_W-1:0] data_i,
  output logic [IMEM_DATA_W-1:0] acc_o
);

  logic [IMEM_DATA_W-1:0] acc_q;
  logic [IMEM_DATA_W-1:0] acc_d;

  // Next sum: clear wins, otherwise fold in the new word when enabled.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = {IMEM_DATA_W{1'b0}};
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end else begin
      acc_d = acc_q;
    end
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {IMEM_DATA_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner shared between CPU fetch and a program loader.
// In IDLE the memory address follows fetch_pc_i. An accepted load stalls the CPU,
// writes ld_count_i words from the loader stream starting at ld_base_i, reads them
// back through the async read port and compares XOR checksums before releasing the CPU.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   fetch_pc_i    CPU fetch byte address, forwarded to memory while idle
//   ld_start_i    load request, only sampled in IDLE
//   ld_base_i     load byte base address (bits [1:0] ignored)
//   ld_count_i    number of words to load
//   bus           loader handshake and memory port (slave modport)
//   cpu_stall_o   CPU must hold its PC
//   ld_busy_o     load or readback in progress
//   ld_done_o     one-cycle pulse at the end of every accepted load request
//   ld_error_o    sticky range-fault / checksum-mismatch flag
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            fetch_pc_i,
  input  logic                   ld_start_i,
  input  logic [31:0]            ld_base_i,
  input  logic [CNT_W-1:0]       ld_count_i,
  imem_load_ctrl_if.slave        bus,
  output logic                   cpu_stall_o,
  output logic                   ld_busy_o,
  output logic                   ld_done_o,
  output logic                   ld_error_o
);

  imem_ld_state_t   state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] bw_q, bw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic                   acc_clr_s;
  logic                   csum_en_s;
  logic                   vsum_en_s;
  logic [IMEM_DATA_W-1:0] csum_s;
  logic [IMEM_DATA_W-1:0] vsum_s;
  logic [IMEM_DATA_W-1:0] vsum_final_s;
  logic [31:0]            end_word_s;
  logic                   range_fault_s;
  logic                   last_s;
  logic [CNT_W-1:0]       word_idx_s;

  // The range check uses the full 30-bit base word so a huge base cannot alias
  // into range through truncation; only in-range loads ever use the latched index.
  assign end_word_s    = (ld_base_i >> 2) + 32'(ld_count_i);
  assign range_fault_s = (end_word_s > 32'(DEPTH));
  assign last_s        = (idx_q == (cnt_q - CNT_W'(1'b1)));
  assign word_idx_s    = bw_q + idx_q;
  // Readback sum including the word presented this cycle.
  assign vsum_final_s  = vsum_s ^ bus.mem_rdata;

  // Checksum of the words accepted from the loader.
  imem_csum_acc u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr_s),
    .en_i   (csum_en_s),
    .data_i (bus.ld_data),
    .acc_o  (csum_s)
  );

  // Checksum of the words read back from memory.
  imem_csum_acc u_vsum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr_s),
    .en_i   (vsum_en_s),
    .data_i (bus.mem_rdata),
    .acc_o  (vsum_s)
  );

  // FSM next-state, index/latch updates and error flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bw_d      = bw_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    acc_clr_s = 1'b0;
    csum_en_s = 1'b0;
    vsum_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          bw_d      = ld_base_i[CNT_W+1:2];
          cnt_d     = ld_count_i;
          idx_d     = {CNT_W{1'b0}};
          acc_clr_s = 1'b1;
          if (range_fault_s) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (ld_count_i == {CNT_W{1'b0}}) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          csum_en_s = 1'b1;
          if (last_s) begin
            idx_d   = {CNT_W{1'b0}};
            state_d = VERIFY;
          end else begin
            idx_d   = idx_q + CNT_W'(1'b1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      VERIFY: begin
        vsum_en_s = 1'b1;
        if (last_s) begin
          idx_d   = {CNT_W{1'b0}};
          state_d = DONE;
          if (vsum_final_s != csum_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          idx_d = idx_q + CNT_W'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, latched request and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= {CNT_W{1'b0}};
      bw_q    <= {CNT_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Memory port mux: fetch owns the port unless a load or readback is running.
  // The write enable follows ld_valid directly so a word is written the cycle it is accepted.
  always_comb begin
    bus.mem_addr  = fetch_pc_i;
    bus.mem_wdata = {IMEM_DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    bus.ld_ready  = 1'b0;
    case (state_q)
      LOAD: begin
        bus.mem_addr  = byte_addr(30'(word_idx_s));
        bus.mem_wdata = bus.ld_data;
        bus.mem_we    = bus.ld_valid;
        bus.ld_ready  = 1'b1;
      end
      VERIFY: begin
        bus.mem_addr  = byte_addr(30'(word_idx_s));
      end
      default: begin
        bus.mem_addr  = fetch_pc_i;
      end
    endcase
  end

  assign cpu_stall_o = (state_q != IDLE);
  assign ld_busy_o   = (state_q != IDLE);
  assign ld_done_o   = (state_q == DONE);
  assign ld_error_o  = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: a 64-word memory model with an optional
// read corruption, directed load scenarios and randomized loads checked against a
// phase-timeline model of each load.
module tb_imem_load_ctrl;
  import imem_ctrl_pkg::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      fetch_pc;
  logic             ld_start;
  logic [31:0]      ld_base;
  logic [CNT_W-1:0] ld_count;
  logic             cpu_stall, ld_busy, ld_done, ld_error;

  imem_load_ctrl_if bus();

  imem_load_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_pc_i  (fetch_pc),
    .ld_start_i  (ld_start),
    .ld_base_i   (ld_base),
    .ld_count_i  (ld_count),
    .bus         (bus),
    .cpu_stall_o (cpu_stall),
    .ld_busy_o   (ld_busy),
    .ld_done_o   (ld_done),
    .ld_error_o  (ld_error)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        clear_mem;
  logic        corrupt_en;
  logic [5:0]  corrupt_word;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  always_comb begin
    bus.mem_rdata = mem[bus.mem_addr[7:2]];
    if (corrupt_en && (bus.mem_addr[7:2] == corrupt_word)) begin
      bus.mem_rdata = mem[bus.mem_addr[7:2]] ^ 32'h0000_0100;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load request followed cycle by cycle. phase: 0 load, 1 readback, 2 done, 3 idle.
  // fixed_gap >= 0 inserts exactly that many idle cycles after the first word;
  // otherwise each offer is withheld with probability gap_pct percent.
  task automatic run_load(input logic [31:0] base, input int count, input int fixed_gap,
                          input int gap_pct, input bit corrupt, input logic [5:0] cword);
    int  bw, idx, phase, gaps, stall_cycles, done_pulses, writes, cycles, bad_words;
    bit  fault, loading, exp_err, err_at_done, v;
    bw      = int'(base[31:2]);
    fault   = (bw + count) > DEPTH;
    loading = !fault && (count > 0);
    exp_err = fault || (loading && corrupt && int'(cword) >= bw && int'(cword) < bw + count);
    while (wq.size() < count) wq.push_back($urandom());
    corrupt_en   = corrupt;
    corrupt_word = cword;

    @(negedge clk);
    ld_start = 1'b1; ld_base = base; ld_count = CNT_W'(count);
    bus.ld_valid = 1'b0; bus.ld_data = $urandom();
    #1;
    check("start_idle_stall", cpu_stall, 1'b0);
    @(negedge clk);

    phase = loading ? 0 : 2;
    idx = 0; gaps = 0; stall_cycles = 0; done_pulses = 0; writes = 0; cycles = 0;
    err_at_done = 1'b0;
    while (phase != 3 && cycles < 600) begin
      ld_start = 1'(($urandom() >> 3) & 1);
      ld_base  = $urandom() & 32'hFF;
      ld_count = CNT_W'($urandom_range(1, 5));
      if (phase == 0) begin
        if (fixed_gap >= 0) v = !(idx == 1 && gaps < fixed_gap);
        else                v = ($urandom_range(0, 99) >= gap_pct);
        bus.ld_valid = v;
        bus.ld_data  = v ? wq[idx] : $urandom();
      end else begin
        v = 1'b0;
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_data  = $urandom();
      end
      #1;
      check("busy_stall",  cpu_stall, 1'b1);
      check("busy_flag",   ld_busy, 1'b1);
      check("ld_ready",    bus.ld_ready, (phase == 0));
      check("mem_we",      bus.mem_we, (phase == 0) && v);
      check("ld_done",     ld_done, (phase == 2));
      if (phase < 2) begin
        check("error_cleared", ld_error, 1'b0);
        check("mem_addr", bus.mem_addr, 32'((bw + idx) * 4));
      end
      if (phase == 0 && v) check("mem_wdata", bus.mem_wdata, wq[idx]);
      if (cpu_stall) stall_cycles++;
      if (bus.mem_we) writes++;
      if (ld_done) begin done_pulses++; err_at_done = ld_error; end
      case (phase)
        0: begin
          if (v) begin
            idx++;
            if (idx == count) begin idx = 0; phase = 1; end
          end else begin
            gaps++;
          end
        end
        1: begin idx++; if (idx == count) phase = 2; end
        default: phase = 3;
      endcase
      cycles++;
      @(negedge clk);
    end
    if (phase != 3) begin
      miscompares++;
      $error("FAIL load_timeout observed=%0d cycles expected=completion", cycles);
    end
    ld_start = 1'b0; bus.ld_valid = 1'b0;
    #1;
    check("stall_cycles", stall_cycles, loading ? 2 * count + gaps + 1 : 1);
    check("done_pulses",  done_pulses, 1);
    check("err_at_done",  err_at_done, exp_err);
    check("write_count",  writes, loading ? count : 0);
    check("after_stall",  cpu_stall, 1'b0);
    check("after_done",   ld_done, 1'b0);
    check("err_sticky",   ld_error, exp_err);
    check("fetch_fwd",    bus.mem_addr, fetch_pc);
    if (loading) for (int i = 0; i < count; i++) ref_mem[bw + i] = wq[i];
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check("mem_image", bad_words, 0);
    corrupt_en = 1'b0;
    wq.delete();
  endtask

  initial begin
    logic [31:0] w0;
    int rb, rc;
    rst_n = 1'b0; clear_mem = 1'b1; corrupt_en = 1'b0; corrupt_word = 6'd0;
    fetch_pc = 32'h10; ld_start = 1'b0; ld_base = 32'h0; ld_count = '0;
    bus.ld_valid = 1'b0; bus.ld_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_done",  ld_done, 1'b0);
    check("rst_error", ld_error, 1'b0);
    check("rst_ready", bus.ld_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; clear_mem = 1'b0;

    // Idle forwarding of fetch_pc.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_pc = (i == 0) ? 32'h10 : $urandom();
      bus.ld_valid = 1'($urandom_range(0, 1));
      #1;
      check("idle_addr",  bus.mem_addr, fetch_pc);
      check("idle_stall", cpu_stall, 1'b0);
      check("idle_we",    bus.mem_we, 1'b0);
    end
    fetch_pc = 32'h10;

    // Three words back to back at address 0.
    wq = {32'hA1, 32'hB2, 32'hC3};
    run_load(32'h0, 3, -1, 0, 1'b0, 6'd0);
    // Two words with a three-cycle gap.
    run_load(32'h40, 2, 3, 0, 1'b0, 6'd0);
    // Range fault at word 62, then a valid load clears the error.
    run_load(32'hF8, 3, -1, 0, 1'b0, 6'd0);
    run_load(32'h20, 2, -1, 0, 1'b0, 6'd0);
    // Base beyond the memory through its upper bits.
    run_load(32'h8000_0004, 1, -1, 0, 1'b0, 6'd0);
    // Zero-length load.
    run_load(32'h30, 0, -1, 0, 1'b0, 6'd0);
    // Readback of word 1 corrupted.
    run_load(32'h80, 4, -1, 0, 1'b1, 6'd33);
    // Load ending on the last memory word.
    run_load(32'hF0, 4, -1, 20, 1'b0, 6'd0);

    // Reset during a load after one word; a second request mid-load is ignored.
    w0 = $urandom();
    @(negedge clk);
    ld_start = 1'b1; ld_base = 32'd160; ld_count = CNT_W'(4); bus.ld_valid = 1'b0;
    @(negedge clk);
    ld_start = 1'b1; ld_base = 32'd0; ld_count = CNT_W'(1);
    bus.ld_valid = 1'b1; bus.ld_data = w0;
    #1;
    check("rl_addr0", bus.mem_addr, 32'd160);
    check("rl_we0",   bus.mem_we, 1'b1);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_data = $urandom();
    #1;
    check("rl_addr1", bus.mem_addr, 32'd164);
    check("rl_stall", cpu_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rl_rst_stall", cpu_stall, 1'b0);
    check("rl_rst_busy",  ld_busy, 1'b0);
    check("rl_rst_ready", bus.ld_ready, 1'b0);
    check("rl_rst_we",    bus.mem_we, 1'b0);
    check("rl_rst_done",  ld_done, 1'b0);
    check("rl_rst_error", ld_error, 1'b0);
    check("rl_rst_addr",  bus.mem_addr, fetch_pc);
    @(negedge clk);
    rst_n = 1'b1; ld_start = 1'b0; bus.ld_valid = 1'b0;
    #1;
    check("rl_idle", cpu_stall, 1'b0);
    ref_mem[40] = w0;
    check("rl_word0", mem[40], w0);
    check("rl_word1", mem[41], ref_mem[41]);

    // Randomized loads, some of them out of range.
    for (int n = 0; n < 12; n++) begin
      rb = $urandom_range(0, 66);
      rc = $urandom_range(0, 8);
      run_load({30'(rb), 2'($urandom_range(0, 3))}, rc, -1, $urandom_range(0, 40),
               1'($urandom_range(0, 3) == 0), 6'(rb + $urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
